tt_sweep_checker: RTL and testbench
===================================

Name: tt_sweep_checker

Overview:
- Synchronous, self-checking exerciser for combinational truth-table blocks.
- Drives every input combination of a DUT with N_IN inputs, waits a settle time, samples N_OUT outputs and compares them with an expected truth table.
- Reports pass/fail, the number of failing vectors and the first failing vector.
- Replaces ad-hoc per-table stimulus sequences with one reusable, parametrised block. It works in simulation and on the board, where outputs go to LEDs.

Parameters:
- N_IN, 3, number of DUT inputs (1..8); the sweep covers 2**N_IN vectors.
- N_OUT, 1, number of DUT outputs checked per vector (1..8).
- SETTLE, 1, wait cycles after stim changes before sampling (0..15).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request a sweep; honoured only in IDLE
- expect_tt  in  N_OUT*2**N_IN  expected outputs; bit [v*N_OUT+k] is output k for vector v
- dut_out  in  N_OUT  DUT outputs
- stim  out  N_IN  DUT input vector; stim[N_IN-1] is the MSB (input A)
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse at end of sweep
- pass  out  1  last sweep had zero mismatches
- err_count  out  N_IN+1  number of mismatching vectors in the last sweep
- first_fail_idx  out  N_IN  index of the first mismatching vector
- first_fail_valid  out  1  first_fail_idx is meaningful

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- Reset values: all outputs are 0, and the FSM is in IDLE. Reset wins over every other event.
- Reset mid-sweep: the FSM returns to IDLE on the next edge. The partial sweep is discarded and done is not pulsed.
- FSM states: IDLE, SETTLE, SAMPLE, FINISH.
- IDLE, with start=1 at an edge:
  - Latch expect_tt into an internal copy; later changes to the port are ignored until the next start.
  - Set stim=0, settle_cnt=SETTLE, err_count=0, first_fail_valid=0, pass=0, busy=1.
  - Go to SETTLE, or to SAMPLE directly if SETTLE=0.
- SETTLE: settle_cnt decrements each cycle; go to SAMPLE when it reaches 0.
- SAMPLE (one cycle):
  - Compare dut_out with the latched bits [stim*N_OUT +: N_OUT].
  - On mismatch, increment err_count. If first_fail_valid=0, also set first_fail_idx=stim and first_fail_valid=1.
  - A vector counts once regardless of how many bits differ.
  - If stim equals 2**N_IN-1, go to FINISH. Otherwise increment stim, reload settle_cnt and go to SETTLE (or stay in SAMPLE if SETTLE=0).
- Timing: each vector occupies exactly SETTLE+1 cycles, so busy is high for exactly 2**N_IN*(SETTLE+1) cycles.
- FINISH (one cycle):
  - busy=0 and done=1.
  - pass = (err_count==0), evaluated including the last vector.
  - Return to IDLE; done falls on the next cycle.
- After a sweep: stim stays at 2**N_IN-1. pass, err_count and the first_fail fields hold until the next start or rst.
- start while busy or in FINISH is ignored; it is not queued.
- start held high continuously: a new sweep begins on the first IDLE cycle after FINISH.
- err_count arithmetic does not wrap; its maximum value 2**N_IN fits in N_IN+1 bits.

Optional Feature:
- Macro: TT_SWEEP_CAPTURE_EN.
- When defined:
  - Adds output capt_tt, width N_OUT*2**N_IN, reset 0.
  - In SAMPLE, dut_out is written into capt_tt[stim*N_OUT +: N_OUT].
  - capt_tt is cleared at start and holds after done, so the measured truth table can be displayed or dumped.
- When undefined: the port and its storage do not exist, and all other behaviour is identical.

Test Plan:
- N_IN=3, N_OUT=1, SETTLE=1, DUT=majority(A,B,C), expect_tt=8'b1110_1000, one start pulse -> busy high for 16 cycles; stim walks 0..7 holding each value for 2 cycles; done pulses once; pass=1, err_count=0, first_fail_valid=0.
- Same setup with expect_tt=8'b1100_1000 (bit 5 flipped) -> pass=0, err_count=1, first_fail_idx=5, first_fail_valid=1.
- Same setup with expect_tt=~8'b1110_1000 -> err_count=8 (4'b1000, no wrap), first_fail_idx=0.
- N_IN=4, N_OUT=2, SETTLE=0, DUT outputs {A&B, C^D}, correct expect_tt -> busy high for exactly 16 cycles, pass=1. Then flip only output bit 1 of vector 15 -> err_count=1, first_fail_idx=15.
- Reset and start interaction:
  - Assert rst for 1 cycle while stim=3 -> next cycle all outputs 0, FSM in IDLE, no done pulse.
  - A fresh start then completes normally.
  - A start pulse mid-sweep is ignored, and the total busy length is unchanged.
- With TT_SWEEP_CAPTURE_EN defined and the first scenario's setup -> capt_tt=8'b1110_1000 after done. With a faulty DUT (stuck-at-0 output) -> capt_tt=0 and err_count=4.

Source files
------------

// File: rtl/tt_sweep_checker.sv
`default_nettype none
// =============================================================================
// tt_sweep_checker : sweeps every input vector of a combinational block and
// compares the sampled outputs against an expected truth table.
// Optional feature macro: TT_SWEEP_CAPTURE_EN (adds capt_tt).
// Revision: 1.0
// =============================================================================
module tt_sweep_checker #(
  parameter int N_IN   = 3,
  parameter int N_OUT  = 1,
  parameter int SETTLE = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [N_OUT*(2**N_IN)-1:0]   expect_tt,
  input  logic [N_OUT-1:0]             dut_out,
  output logic [N_IN-1:0]              stim,
  output logic                         busy,
  output logic                         done,
  output logic                         pass,
  output logic [N_IN:0]                err_count,
  output logic [N_IN-1:0]              first_fail_idx,
  output logic                         first_fail_valid
`ifdef TT_SWEEP_CAPTURE_EN
  ,
  output logic [N_OUT*(2**N_IN)-1:0]   capt_tt
`endif
);

  localparam int              TT_W      = N_OUT * (2 ** N_IN);
  localparam logic [N_IN-1:0] LAST_VEC  = {N_IN{1'b1}};
  localparam logic [3:0]      SETTLE_LD = 4'(SETTLE);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  state_t           state;
  logic [3:0]       settle_cnt;
  logic [TT_W-1:0]  tt_q;
  logic [N_OUT-1:0] exp_bits;
  logic             mismatch;
  logic [N_IN:0]    err_next;

  // A vector counts once no matter how many of its output bits differ.
  assign exp_bits = tt_q[int'(stim)*N_OUT +: N_OUT];
  assign mismatch = (dut_out != exp_bits);
  assign err_next = err_count + {{N_IN{1'b0}}, mismatch};

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= ST_IDLE;
      settle_cnt       <= '0;
      tt_q             <= '0;
      stim             <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      err_count        <= '0;
      first_fail_idx   <= '0;
      first_fail_valid <= 1'b0;
`ifdef TT_SWEEP_CAPTURE_EN
      capt_tt          <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            tt_q             <= expect_tt;
            stim             <= '0;
            settle_cnt       <= SETTLE_LD;
            err_count        <= '0;
            first_fail_valid <= 1'b0;
            pass             <= 1'b0;
            busy             <= 1'b1;
`ifdef TT_SWEEP_CAPTURE_EN
            capt_tt          <= '0;
`endif
            state            <= (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          settle_cnt <= settle_cnt - 4'd1;
          if (settle_cnt <= 4'd1) state <= ST_SAMPLE;
        end
        ST_SAMPLE: begin
          err_count <= err_next;
          if (mismatch && !first_fail_valid) begin
            first_fail_idx   <= stim;
            first_fail_valid <= 1'b1;
          end
`ifdef TT_SWEEP_CAPTURE_EN
          capt_tt[int'(stim)*N_OUT +: N_OUT] <= dut_out;
`endif
          if (stim == LAST_VEC) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == '0);
            state <= ST_FINISH;
          end else begin
            stim       <= stim + 1'b1;
            settle_cnt <= SETTLE_LD;
            state      <= (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;
          end
        end
        ST_FINISH: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tt_sweep_checker.sv
`default_nettype none
// =============================================================================
// tb_tt_sweep_checker : randomized sweeps of two configurations against a
// truth-table reference model. Honours TT_SWEEP_CAPTURE_EN.
// Revision: 1.0
// =============================================================================
module tb_tt_sweep_checker;

  localparam int LIMIT = 200;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  int          sel = 0;
  logic [31:0] dev_tt = '0;
  logic [31:0] exp_port = '0;

  // Configuration A: N_IN=3, N_OUT=1, SETTLE=1
  logic       start_a, dut_out_a, busy_a, done_a, pass_a, ffv_a;
  logic [2:0] stim_a, ffi_a;
  logic [3:0] err_a;
  // Configuration B: N_IN=4, N_OUT=2, SETTLE=0
  logic       start_b, busy_b, done_b, pass_b, ffv_b;
  logic [1:0] dut_out_b;
  logic [3:0] stim_b, ffi_b;
  logic [4:0] err_b;
`ifdef TT_SWEEP_CAPTURE_EN
  logic [7:0]  capt_a;
  logic [31:0] capt_b;
`endif

  always #5 clk = ~clk;

  assign start_a   = start & (sel == 0);
  assign start_b   = start & (sel == 1);
  assign dut_out_a = dev_tt[stim_a];
  assign dut_out_b = dev_tt[{stim_b, 1'b0} +: 2];

  tt_sweep_checker #(.N_IN(3), .N_OUT(1), .SETTLE(1)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .expect_tt(exp_port[7:0]),
    .dut_out(dut_out_a), .stim(stim_a), .busy(busy_a), .done(done_a),
    .pass(pass_a), .err_count(err_a), .first_fail_idx(ffi_a),
    .first_fail_valid(ffv_a)
`ifdef TT_SWEEP_CAPTURE_EN
    , .capt_tt(capt_a)
`endif
  );

  tt_sweep_checker #(.N_IN(4), .N_OUT(2), .SETTLE(0)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .expect_tt(exp_port),
    .dut_out(dut_out_b), .stim(stim_b), .busy(busy_b), .done(done_b),
    .pass(pass_b), .err_count(err_b), .first_fail_idx(ffi_b),
    .first_fail_valid(ffv_b)
`ifdef TT_SWEEP_CAPTURE_EN
    , .capt_tt(capt_b)
`endif
  );

  int   obs_stim, obs_err, obs_ffi;
  logic obs_busy, obs_done, obs_pass, obs_ffv;
  logic [31:0] obs_capt;

  always_comb begin
    obs_capt = '0;
    if (sel == 0) begin
      obs_stim = int'(stim_a); obs_err = int'(err_a); obs_ffi = int'(ffi_a);
      obs_busy = busy_a; obs_done = done_a; obs_pass = pass_a; obs_ffv = ffv_a;
`ifdef TT_SWEEP_CAPTURE_EN
      obs_capt = {24'd0, capt_a};
`endif
    end else begin
      obs_stim = int'(stim_b); obs_err = int'(err_b); obs_ffi = int'(ffi_b);
      obs_busy = busy_b; obs_done = done_b; obs_pass = pass_b; obs_ffv = ffv_b;
`ifdef TT_SWEEP_CAPTURE_EN
      obs_capt = capt_b;
`endif
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Reference: walk the truth table vector by vector.
  task automatic model(input int nin, input int nout, input logic [31:0] dev,
                       input logic [31:0] exp, output int errs, output int first);
    errs  = 0;
    first = -1;
    for (int v = 0; v < (1 << nin); v++) begin
      bit differs = 0;
      for (int k = 0; k < nout; k++)
        if (dev[v*nout+k] != exp[v*nout+k]) differs = 1;
      if (differs) begin
        errs++;
        if (first < 0) first = v;
      end
    end
  endtask

  function automatic logic [31:0] majority_tt();
    logic [31:0] t = '0;
    for (int v = 0; v < 8; v++)
      t[v] = (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
    return t;
  endfunction

  function automatic logic [31:0] and_xor_tt();
    logic [31:0] t = '0;
    for (int v = 0; v < 16; v++) begin
      t[2*v+1] = v[3] & v[2];
      t[2*v]   = v[1] ^ v[0];
    end
    return t;
  endfunction

  task automatic run_sweep(input int s, input logic [31:0] dev, input logic [31:0] exp,
                           input int inject_at);
    int nin, nout, settle, errs, first, busy_len, stim_bad, seen_done;
    logic [31:0] mask;
    nin    = (s == 0) ? 3 : 4;
    nout   = (s == 0) ? 1 : 2;
    settle = (s == 0) ? 1 : 0;
    mask   = (s == 0) ? 32'h0000_00FF : 32'hFFFF_FFFF;
    model(nin, nout, dev & mask, exp & mask, errs, first);

    @(negedge clk);
    sel = s; dev_tt = dev; exp_port = exp; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    exp_port = $urandom;  // must be ignored once the sweep has started
    busy_len = 0; stim_bad = 0; seen_done = 0;
    for (int c = 0; c < LIMIT && seen_done == 0; c++) begin
      if (obs_busy) begin
        if (obs_stim != busy_len / (settle + 1)) stim_bad++;
        start = (busy_len == inject_at);
        busy_len++;
      end else if (obs_done) begin
        seen_done = 1;
      end
      if (seen_done == 0) @(negedge clk);
    end
    start = 1'b0;

    check("busy_len", busy_len, (1 << nin) * (settle + 1));
    check("stim_walk", stim_bad, 0);
    check("done_seen", seen_done, 1);
    check("pass", obs_pass, (errs == 0));
    check("err_count", obs_err, errs);
    check("ff_valid", obs_ffv, (errs != 0));
    if (errs != 0) check("ff_idx", obs_ffi, first);
`ifdef TT_SWEEP_CAPTURE_EN
    check("capt_tt", obs_capt, dev & mask);
`endif
    @(negedge clk);
    check("done_fall", obs_done, 0);
    check("busy_after", obs_busy, 0);
    check("stim_hold", obs_stim, (1 << nin) - 1);
    check("err_hold", obs_err, errs);
  endtask

  initial begin
    logic [31:0] maj, ax;
    int got3, dones;
    maj = majority_tt();
    ax  = and_xor_tt();

    repeat (3) @(negedge clk);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_pass", pass_a, 0);
    check("rst_err", err_a, 0);
    check("rst_ffv", ffv_a, 0);
    check("rst_stim", stim_a, 0);
    check("rst_busy_b", busy_b, 0);
    rst = 1'b0;

    check("maj_table", maj, 32'h0000_00E8);
    run_sweep(0, maj, 32'h0000_00E8, -1);
    run_sweep(0, maj, 32'h0000_00C8, -1);
    run_sweep(0, maj, ~32'h0000_00E8, -1);
    run_sweep(0, 32'h0, 32'h0000_00E8, -1);
    run_sweep(1, ax, ax, -1);
    run_sweep(1, ax, ax ^ 32'h8000_0000, -1);
    run_sweep(0, maj, 32'h0000_00E8, 5);

    for (int i = 0; i < 10; i++) begin
      int s, inj;
      logic [31:0] d, m;
      s   = $urandom_range(0, 1);
      d   = $urandom;
      m   = ($urandom_range(0, 2) == 0) ? 32'h0 : ($urandom & $urandom & $urandom);
      inj = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 10) : -1;
      run_sweep(s, d, d ^ m, inj);
    end

    // Reset in the middle of a failing sweep.
    @(negedge clk);
    sel = 0; dev_tt = maj; exp_port = ~32'h0000_00E8; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    got3 = 0;
    for (int c = 0; c < LIMIT && got3 == 0; c++) begin
      if (busy_a && stim_a == 3'd3) got3 = 1;
      else @(negedge clk);
    end
    check("reach_stim3", got3, 1);
    check("err_before_rst", (err_a != 0), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy", busy_a, 0);
    check("mid_rst_stim", stim_a, 0);
    check("mid_rst_err", err_a, 0);
    check("mid_rst_ffv", ffv_a, 0);
    check("mid_rst_done", done_a, 0);
    dones = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done_a || busy_a) dones++;
    end
    check("no_done_after_rst", dones, 0);
    run_sweep(0, maj, 32'h0000_00E8, -1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
